// File: rtl/fp_multiplier_pkg.sv
// Shared binary32 definitions for the floating-point multiplier.
package fp_multiplier_pkg;

    localparam int BIAS   = 127;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;

    typedef struct packed {
        logic                sign;
        logic [EXP_W-1:0]    exponent;
        logic [FRAC_W-1:0]   fraction;
    } fp32_t;

    // Exponent field of zero covers both zero and denormal operands.
    function automatic logic is_zero_exp(input fp32_t value);
        return (value.exponent == 8'h00);
    endfunction

endpackage

// File: rtl/fp_multiplier_mant.sv
// Combinational 24x24 unsigned significand multiplier.
module fp_mant_mult (
    input  logic [23:0] a,
    input  logic [23:0] b,
    output logic [47:0] product
);

    assign product = {24'h000000, a} * {24'h000000, b};

endmodule

// File: rtl/fp_multiplier.sv
// Two-stage binary32 multiplier: operand registers, then normalised,
// truncated result with an out-of-range exponent flag.
module fp_multiplier
    import fp_multiplier_pkg::*;
(
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [31:0] out,
    output logic        overflow,
    input  logic        enable,
    input  logic        reset,
    input  logic        clk
);

    localparam logic signed [9:0] BIAS_10 = 10'(BIAS);

    fp32_t              a_r;
    fp32_t              b_r;
    logic [47:0]        product_s;
    logic               norm_s;
    logic [22:0]        frac_s;
    logic signed [9:0]  exp_s;
    logic [31:0]        result_s;
    logic               ovf_s;

    fp_mant_mult u_mant (
        .a       ({1'b1, a_r.fraction}),
        .b       ({1'b1, b_r.fraction}),
        .product (product_s)
    );

    // Stage 1: capture operands on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r <= '0;
            b_r <= '0;
        end else if (enable) begin
            a_r <= fp32_t'(in1);
            b_r <= fp32_t'(in2);
        end else begin
            a_r <= a_r;
            b_r <= b_r;
        end
    end

    // Normalise the product, form the wide signed exponent and the result word.
    always_comb begin
        norm_s   = product_s[47];
        frac_s   = 23'h000000;
        exp_s    = $signed({2'b00, a_r.exponent}) + $signed({2'b00, b_r.exponent})
                   - BIAS_10 + $signed({9'b000000000, norm_s});
        result_s = 32'h00000000;
        ovf_s    = 1'b0;
        if (norm_s) begin
            frac_s = product_s[46:24];
        end else begin
            frac_s = product_s[45:23];
        end
        if (is_zero_exp(a_r) || is_zero_exp(b_r)) begin
            // Zero or denormal operand: positive zero regardless of signs.
            result_s = 32'h00000000;
            ovf_s    = 1'b0;
        end else begin
            // Exponent wraps modulo 256; the flag reports the wrap.
            result_s = {a_r.sign ^ b_r.sign, exp_s[7:0], frac_s};
            ovf_s    = (exp_s > 10'sd254) || (exp_s < 10'sd1);
        end
    end

    // Stage 2: register the result and flag on enabled edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out      <= 32'h00000000;
            overflow <= 1'b0;
        end else if (enable) begin
            out      <= result_s;
            overflow <= ovf_s;
        end else begin
            out      <= out;
            overflow <= overflow;
        end
    end

endmodule

// File: tb/tb_fp_multiplier.sv
// Directed, table-driven bench for fp_multiplier.
module tb_fp_multiplier;

    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] out;
    logic        overflow;
    logic        enable;
    logic        reset;
    logic        clk;

    int applied;
    int miscompares;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        v;
    } vec_t;

    vec_t vecs[16];
    int   num_vec;

    fp_multiplier dut (
        .in1      (in1),
        .in2      (in2),
        .out      (out),
        .overflow (overflow),
        .enable   (enable),
        .reset    (reset),
        .clk      (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] exp_out, input logic exp_ovf);
        applied++;
        if (out !== exp_out || overflow !== exp_ovf) begin
            miscompares++;
            $display("FAIL %s: got out=%08h ovf=%0b, expected out=%08h ovf=%0b",
                     nm, out, overflow, exp_out, exp_ovf);
        end
    endtask

    task automatic edge_wait();
        @(posedge clk);
        #1;
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        num_vec     = 0;

        vecs[num_vec++] = '{32'h40aa6666, 32'h40aa6666, 32'h41e2d850, 1'b0};
        vecs[num_vec++] = '{32'hc0080000, 32'hc0680000, 32'h40f68000, 1'b0};
        vecs[num_vec++] = '{32'hbf200000, 32'h3fd00000, 32'hbf820000, 1'b0};
        vecs[num_vec++] = '{32'h40a80000, 32'hc0440000, 32'hc180a000, 1'b0};
        vecs[num_vec++] = '{32'h00000000, 32'h40a80000, 32'h00000000, 1'b0};
        vecs[num_vec++] = '{32'h00000000, 32'hc0480000, 32'h00000000, 1'b0};
        vecs[num_vec++] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
        vecs[num_vec++] = '{32'h80000000, 32'hc0480000, 32'h00000000, 1'b0};
        vecs[num_vec++] = '{32'h3f800000, 32'h40480000, 32'h40480000, 1'b0};
        vecs[num_vec++] = '{32'h3f800000, 32'hc0480000, 32'hc0480000, 1'b0};
        vecs[num_vec++] = '{32'h7f000000, 32'h7f000000, 32'h3e800000, 1'b1};
        vecs[num_vec++] = '{32'h7f000000, 32'h3f800000, 32'h7f000000, 1'b0};
        vecs[num_vec++] = '{32'h7f000000, 32'h40000000, 32'h7f800000, 1'b1};
        vecs[num_vec++] = '{32'h00800000, 32'h3f800000, 32'h00800000, 1'b0};
        vecs[num_vec++] = '{32'h00800000, 32'h3f000000, 32'h00000000, 1'b1};
        vecs[num_vec++] = '{32'h00800000, 32'h00800000, 32'h41800000, 1'b1};

        in1    = 32'h40aa6666;
        in2    = 32'h40aa6666;
        enable = 1'b1;
        reset  = 1'b1;
        repeat (2) edge_wait();
        check("reset_state", 32'h00000000, 1'b0);

        @(negedge clk);
        reset = 1'b0;

        // Table: two enabled edges from operand to result.
        for (int i = 0; i < num_vec; i++) begin
            @(negedge clk);
            in1 = vecs[i].a;
            in2 = vecs[i].b;
            repeat (2) edge_wait();
            check($sformatf("vec%0d_%08h_x_%08h", i, vecs[i].a, vecs[i].b), vecs[i].y, vecs[i].v);
        end

        // Truncation case with enable held for four clocks.
        @(negedge clk);
        in1 = 32'h40aa6666;
        in2 = 32'h40aa6666;
        repeat (4) edge_wait();
        check("trunc_4clk", 32'h41e2d850, 1'b0);

        // Hold: inputs change while disabled, nothing moves.
        @(negedge clk);
        in1 = 32'h3f800000;
        in2 = 32'h40480000;
        repeat (2) edge_wait();
        check("hold_setup", 32'h40480000, 1'b0);
        @(negedge clk);
        enable = 1'b0;
        in1    = 32'h7f000000;
        in2    = 32'h7f000000;
        repeat (3) edge_wait();
        check("hold_disabled", 32'h40480000, 1'b0);
        @(negedge clk);
        enable = 1'b1;
        edge_wait();
        check("latency_edge1", 32'h40480000, 1'b0);
        edge_wait();
        check("latency_edge2", 32'h3e800000, 1'b1);

        // Reset mid-operation: immediate clear, in-flight operands discarded.
        @(negedge clk);
        in1 = 32'hc0080000;
        in2 = 32'hc0680000;
        edge_wait();
        #2;
        reset = 1'b1;
        #1;
        check("reset_async", 32'h00000000, 1'b0);
        edge_wait();
        check("reset_over_enable", 32'h00000000, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        edge_wait();
        check("post_reset_edge1", 32'h00000000, 1'b0);
        edge_wait();
        check("post_reset_edge2", 32'h40f68000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
